// File: rtl/square_painter.sv
// -----------------------------------------------------------------------------
// square_painter
//
// Pixel rasteriser for the 160x120 VGA adapter. Accepts one square request at a
// time (top-left corner + 3-bit colour) over a valid/ready handshake and expands
// it into SIZE x SIZE single-pixel writes, one per clock, in row-major order.
// Pixels that land off-screen still take their cycle but are not plotted.
// Erasing is simply a request with colour 3'b000.
//
// Ports:
//   clk         system clock, all state on posedge
//   resetn      synchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request this cycle (IDLE only)
//   req_x       square top-left x (8 bits)
//   req_y       square top-left y (7 bits)
//   req_colour  square colour (RGB, 3 bits)
//   vga_x       pixel x to adapter
//   vga_y       pixel y to adapter
//   vga_colour  pixel colour to adapter
//   vga_plot    adapter write enable
//   busy        high while a square is being drawn
//   done        one-cycle pulse after the last pixel of a square
//
// Timing (accept edge = E0): pixel (0,0) is presented in the cycle after E0,
// the last pixel SIZE*SIZE cycles after E0, done in cycle SIZE*SIZE+1 and
// req_ready is back in cycle SIZE*SIZE+2. All vga_* outputs are decoded from
// registers only, so there is no combinational req_* -> vga_* path.
// -----------------------------------------------------------------------------
module square_painter #(
  parameter int unsigned SIZE     = 4,   // legal range 1..8
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  // Index of the last pixel in a row/column; dx/dy are 3-bit so SIZE=8 maps to 7.
  localparam logic [2:0] LastIdx = 3'(SIZE - 1);
  // Clip limits sized to match the widened coordinate sums below.
  localparam logic [8:0] XLimit  = 9'(SCREEN_W);
  localparam logic [7:0] YLimit  = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_e;

  state_e     state_q, state_d;

  // Captured request and in-square offsets.
  logic [7:0] x_q,   x_d;
  logic [6:0] y_q,   y_d;
  logic [2:0] col_q, col_d;
  logic [2:0] dx_q,  dx_d;
  logic [2:0] dy_q,  dy_d;

  logic       accept;
  logic       last_pixel;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       on_screen;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign accept     = (state_q == StIdle) && req_valid;
  assign last_pixel = (dx_q == LastIdx) && (dy_q == LastIdx);

  // Sums carry one extra bit so a square straddling the 8-bit/7-bit coordinate
  // range is clipped instead of wrapping back onto the screen.
  assign x_sum     = {1'b0, x_q} + {6'b000000, dx_q};
  assign y_sum     = {1'b0, y_q} + {5'b00000, dy_q};
  assign on_screen = (x_sum < XLimit) && (y_sum < YLimit);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (last_pixel) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    vga_plot   = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
      end
      StDraw: begin
        busy       = 1'b1;
        vga_x      = x_sum[7:0];
        vga_y      = y_sum[6:0];
        vga_colour = col_q;
        vga_plot   = on_screen;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request capture and raster counters
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (accept) begin
      // Request fields are only looked at here; later changes are ignored.
      x_d   = req_x;
      y_d   = req_y;
      col_d = req_colour;
      dx_d  = 3'd0;
      dy_d  = 3'd0;
    end else if (state_q == StDraw) begin
      if (dx_q == LastIdx) begin
        dx_d = 3'd0;
        dy_d = dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q   <= 8'd0;
      y_q   <= 7'd0;
      col_q <= 3'd0;
      dx_q  <= 3'd0;
      dy_q  <= 3'd0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
    end
  end

endmodule

// File: tb/tb_square_painter.sv
// -----------------------------------------------------------------------------
// Testbench for square_painter. Three instances (SIZE = 4, 1, 8) share clock,
// reset and request fields; each has its own req_valid. A cycle-level model
// derives expected outputs from the captured request and the number of cycles
// elapsed since acceptance; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_square_painter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] valid;
  logic [7:0] rx;
  logic [6:0] ry;
  logic [2:0] rc;

  logic       ready[3];
  logic       busy[3];
  logic       done[3];
  logic       plot[3];
  logic [7:0] vx[3];
  logic [6:0] vy[3];
  logic [2:0] vc[3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  square_painter #(.SIZE(4)) u_s4 (
    .clk(clk), .resetn(resetn), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_x(rx), .req_y(ry), .req_colour(rc), .vga_x(vx[0]), .vga_y(vy[0]),
    .vga_colour(vc[0]), .vga_plot(plot[0]), .busy(busy[0]), .done(done[0])
  );

  square_painter #(.SIZE(1)) u_s1 (
    .clk(clk), .resetn(resetn), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_x(rx), .req_y(ry), .req_colour(rc), .vga_x(vx[1]), .vga_y(vy[1]),
    .vga_colour(vc[1]), .vga_plot(plot[1]), .busy(busy[1]), .done(done[1])
  );

  square_painter #(.SIZE(8)) u_s8 (
    .clk(clk), .resetn(resetn), .req_valid(valid[2]), .req_ready(ready[2]),
    .req_x(rx), .req_y(ry), .req_colour(rc), .vga_x(vx[2]), .vga_y(vy[2]),
    .vga_colour(vc[2]), .vga_plot(plot[2]), .busy(busy[2]), .done(done[2])
  );

  function automatic int sz(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Model: per instance, whether a square is in flight, how many cycles since
  // it was accepted (1..S*S = pixels, S*S+1 = done) and the captured request.
  // ---------------------------------------------------------------------------
  bit live = 1'b0;
  bit m_act[3];
  int m_t[3];
  int m_x[3];
  int m_y[3];
  int m_c[3];

  always @(posedge clk) begin
    live <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        m_act[k] <= 1'b0;
        m_t[k]   <= 0;
      end else if (!m_act[k]) begin
        if (valid[k]) begin
          m_act[k] <= 1'b1;
          m_t[k]   <= 1;
          m_x[k]   <= int'(rx);
          m_y[k]   <= int'(ry);
          m_c[k]   <= int'(rc);
        end
      end else if (m_t[k] == sz(k) * sz(k) + 1) begin
        m_act[k] <= 1'b0;
      end else begin
        m_t[k] <= m_t[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Checks every instance against the model; runs once per negedge.
  task automatic compare_cycle();
    if (!live) return;
    for (int k = 0; k < 3; k++) begin
      int s, i, ex, ey, ec;
      bit er, eb, ed, ep, cxy;
      s = sz(k);
      er = 1'b0; eb = 1'b0; ed = 1'b0; ep = 1'b0; cxy = 1'b1;
      ex = 0; ey = 0; ec = 0;
      if (!m_act[k]) begin
        er = 1'b1;
      end else if (m_t[k] <= s * s) begin
        i   = m_t[k] - 1;
        ex  = m_x[k] + i % s;
        ey  = m_y[k] + i / s;
        eb  = 1'b1;
        ec  = m_c[k];
        ep  = (ex < 160) && (ey < 120);
        cxy = ep;
      end else begin
        ed = 1'b1;
      end
      chk("req_ready", k, 32'(ready[k]), 32'(er));
      chk("busy", k, 32'(busy[k]), 32'(eb));
      chk("done", k, 32'(done[k]), 32'(ed));
      chk("vga_plot", k, 32'(plot[k]), 32'(ep));
      chk("vga_colour", k, 32'(vc[k]), ec);
      if (cxy) begin
        chk("vga_x", k, 32'(vx[k]), ex);
        chk("vga_y", k, 32'(vy[k]), ey);
      end
    end
  endtask

  // All stimulus advances through here so every negedge is compared.
  task automatic step();
    @(negedge clk);
    compare_cycle();
  endtask

  // Issue one request on instance k and measure it. Cycle numbers count
  // negedges after the accept edge.
  task automatic run_req(input int k, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input int exp_plots,
                         input int exp_done);
    int w, plots, done_cyc, fx, fy;
    rx = x; ry = y; rc = c;
    valid[k] = 1'b1;
    w = 0;
    while (m_act[k] && w < 200) begin
      step();
      w++;
    end
    step();
    valid[k] = 1'b0;
    plots = 0; done_cyc = -1; fx = -1; fy = -1;
    for (int cy = 1; cy <= 150; cy++) begin
      if (plot[k] === 1'b1) begin
        if (plots == 0) begin
          fx = int'(vx[k]);
          fy = int'(vy[k]);
        end
        plots++;
      end
      if (done[k] === 1'b1) begin
        done_cyc = cy;
        break;
      end
      step();
    end
    chk("plot_count", k, plots, exp_plots);
    chk("done_cycle", k, done_cyc, exp_done);
    if (exp_plots > 0) begin
      chk("first_x", k, fx, int'(x));
      chk("first_y", k, fy, int'(y));
    end
    step();
    chk("ready_back", k, 32'(ready[k]), 32'd1);
  endtask

  initial begin
    int p1, p2, acc, ndone;
    resetn = 1'b0;
    valid  = 3'b001;
    rx = 8'd50; ry = 7'd50; rc = 3'b111;

    // Reset held two edges with req_valid high: nothing accepted.
    step();
    step();
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    resetn = 1'b1;
    valid  = 3'b000;
    step();
    chk("rst_ready", 0, 32'(ready[0]), 32'd1);
    chk("rst_plot", 0, 32'(plot[0]), 32'd0);
    chk("rst_done", 0, 32'(done[0]), 32'd0);

    // Basic draw, clipped corner, fully off-screen origin.
    run_req(0, 8'd10, 7'd112, 3'b100, 16, 17);
    run_req(0, 8'd158, 7'd118, 3'b110, 4, 17);
    run_req(0, 8'd200, 7'd0, 3'b001, 0, 17);

    // Back-to-back with req_valid held and request fields changing mid-draw.
    rx = 8'd20; ry = 7'd112; rc = 3'b100;
    valid[0] = 1'b1;
    step();
    p1 = 0; acc = -1;
    for (int cy = 1; cy <= 40; cy++) begin
      if (plot[0] === 1'b1) p1++;
      if (cy == 5) rx = 8'd99;
      if (cy == 17) begin
        rx = 8'd30;
        rc = 3'b000;
      end
      if (ready[0] === 1'b1) begin
        acc = cy;
        break;
      end
      step();
    end
    chk("b2b_accept_cycle", 0, acc, 18);
    chk("b2b_first_plots", 0, p1, 16);
    step();
    valid[0] = 1'b0;
    p2 = 0;
    for (int cy = 1; cy <= 16; cy++) begin
      if (plot[0] === 1'b1 && vx[0] >= 8'd30 && vx[0] <= 8'd33 && vc[0] == 3'b000) p2++;
      step();
    end
    chk("b2b_black_plots", 0, p2, 16);
    chk("b2b_done", 0, 32'(done[0]), 32'd1);
    step();

    // Reset while the 6th pixel is on the outputs.
    rx = 8'd10; ry = 7'd20; rc = 3'b010;
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    repeat (5) step();
    chk("mid_plot_before", 0, 32'(plot[0]), 32'd1);
    resetn = 1'b0;
    step();
    chk("mid_plot_after", 0, 32'(plot[0]), 32'd0);
    chk("mid_done_after", 0, 32'(done[0]), 32'd0);
    resetn = 1'b1;
    ndone = 0;
    for (int cy = 0; cy < 20; cy++) begin
      step();
      if (done[0] === 1'b1) ndone++;
    end
    chk("mid_no_done", 0, ndone, 0);
    chk("mid_ready", 0, 32'(ready[0]), 32'd1);

    // SIZE sweep.
    run_req(1, 8'd5, 7'd5, 3'b001, 1, 2);
    run_req(2, 8'd3, 7'd4, 3'b110, 64, 65);
    run_req(2, 8'd155, 7'd115, 3'b010, 25, 65);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
